// File: rtl/uart_rx_64.sv
// uart_rx_64: 8N1 serial receiver that packs eight consecutive good bytes
// into one 64-bit word. The first byte received lands in the top byte.
//
//  state | meaning
//  IDLE  | line idle, waiting for a low level on rxs
//  START | timing to mid start bit to confirm a real start
//  DATA  | sampling eight data bits at mid-bit, LSB first
//  STOP  | sampling the stop bit; good byte goes to the assembler
module uart_rx_64 #(
   parameter int CLK_F        = 50_000_000,
   parameter int UART_BPS     = 115200,
   parameter int CLK_GOAL     = CLK_F / UART_BPS,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rxd,
   output logic [63:0] data_64,
   output logic        data_valid,
   output logic        frame_err,
   output logic        rx_busy
);

   localparam int TW     = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
   localparam int TO_CYC = TIMEOUT_BITS * CLK_GOAL;
   localparam int IW     = $clog2(TO_CYC + 1);

   localparam logic [TW-1:0] T_HALF = TW'(CLK_GOAL / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLK_GOAL - 1);
   localparam logic [IW-1:0] I_LAST = IW'(TO_CYC - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nx;
   logic          rx_meta, rxs;
   logic [TW-1:0] timer;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic [55:0]   word;
   logic [2:0]    byte_cnt;
   logic [IW-1:0] idle_cnt;

   logic timer_clr, shift_en, byte_ok, byte_bad, to_hit, idle_run;

   // Two-flop synchronizer for the asynchronous serial line, idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rxs     <= rx_meta;
      end
   end

   // Bit FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Bit FSM next state and per-cycle strobes.
   always_comb begin
      state_nx  = state;
      timer_clr = 1'b0;
      shift_en  = 1'b0;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_nx  = START;
               timer_clr = 1'b1;
            end
         end
         START: begin
            if (timer == T_HALF) begin
               timer_clr = 1'b1;
               state_nx  = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer == T_LAST) begin
               timer_clr = 1'b1;
               shift_en  = 1'b1;
               if (bit_cnt == 3'd7) state_nx = STOP;
            end
         end
         STOP: begin
            if (timer == T_LAST) begin
               timer_clr = 1'b1;
               state_nx  = IDLE;
               byte_ok   = rxs;
               byte_bad  = !rxs;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bit timer: free-runs inside a frame, parked at zero while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         timer <= '0;
      else if (timer_clr || state == IDLE) timer <= '0;
      else                                timer <= timer + 1'b1;
   end

   // Data bit capture, LSB first; bit_cnt wraps to 0 after the eighth bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= '0;
         bit_cnt <= '0;
      end else if (shift_en) begin
         shift   <= {rxs, shift[7:1]};
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign idle_run = (state == IDLE) && (byte_cnt != 3'd0);
   assign to_hit   = idle_run && (idle_cnt == I_LAST);

   // Inter-byte idle timer; expiry abandons a partially built word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           idle_cnt <= '0;
      else if (byte_ok || byte_bad || to_hit) idle_cnt <= '0;
      else if (idle_run)                    idle_cnt <= idle_cnt + 1'b1;
   end

   // Word assembler and registered result strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word       <= '0;
         byte_cnt   <= '0;
         data_64    <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (byte_ok) begin
            word <= {word[47:0], shift};
            if (byte_cnt == 3'd7) begin
               data_64    <= {word, shift};
               data_valid <= 1'b1;
               byte_cnt   <= '0;
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end else if (byte_bad) begin
            frame_err <= 1'b1;
            byte_cnt  <= '0;
         end else if (to_hit) begin
            byte_cnt <= '0;
         end
      end
   end

   assign rx_busy = (state != IDLE) || (byte_cnt != 3'd0);

endmodule

// File: tb/tb_uart_rx_64.sv
// tb_uart_rx_64: drives serial frames into uart_rx_64 at a reduced bit
// period and checks reassembled words through a scoreboard queue.
module tb_uart_rx_64;

   localparam int G  = 16;          // clocks per bit in this bench
   localparam int H  = G / 2;
   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rxd = 1'b1;
   logic [63:0] data_64;
   logic        data_valid, frame_err, rx_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int dv_run = 0;
   int fe_run = 0;
   logic [63:0] sb[$];
   int valid_cyc[$];

   uart_rx_64 #(.CLK_F(1_600_000), .UART_BPS(100_000), .TIMEOUT_BITS(TO)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd),
      .data_64(data_64), .data_valid(data_valid),
      .frame_err(frame_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard compare on every data_valid, pulse widths.
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (data_valid) begin
            n_valid++;
            dv_run++;
            valid_cyc.push_back(cyc);
            if (sb.size() == 0) chk("sb_depth_on_valid", 64'(sb.size()), 64'd1);
            else                chk("word", data_64, sb.pop_front());
         end else if (dv_run != 0) begin
            chk("dv_width", 64'(dv_run), 64'd1);
            dv_run = 0;
         end
         if (frame_err) begin
            n_ferr++;
            fe_run++;
         end else if (fe_run != 0) begin
            chk("fe_width", 64'(fe_run), 64'd1);
            fe_run = 0;
         end
      end
   end

   task automatic send_bit(input logic b);
      uart_rxd = b;
      repeat (G) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic send_word(input logic [63:0] w);
      sb.push_back(w);
      for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
   endtask

   task automatic idle_bits(input int n);
      uart_rxd = 1'b1;
      repeat (n * G) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 20 * G) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int v0, f0, nq;
      repeat (3) @(negedge clk);
      chk("rst_data_64", data_64, 64'd0);
      chk("rst_data_valid", 64'(data_valid), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_rx_busy", 64'(rx_busy), 64'd0);
      rst_n = 1'b1;
      idle_bits(2);

      // Single word.
      send_word(64'h0123_4567_89AB_CDEF);
      idle_bits(2);
      drain("drain_w1");
      chk("w1_hold", data_64, 64'h0123_4567_89AB_CDEF);
      chk("w1_no_ferr", 64'(n_ferr), 64'd0);

      // Two words with no idle time between them.
      send_word(64'h0011_2233_4455_6677);
      send_word(64'hFEDC_BA98_7654_3210);
      idle_bits(2);
      drain("drain_b2b");
      nq = valid_cyc.size();
      chk("b2b_spacing", 64'(valid_cyc[nq-1] - valid_cyc[nq-2]), 64'(80 * G));

      // Short low glitch rejected as false start.
      v0 = n_valid; f0 = n_ferr;
      uart_rxd = 1'b0;
      repeat (5) @(negedge clk);
      chk("glitch_busy_high", 64'(rx_busy), 64'd1);
      @(negedge clk);
      uart_rxd = 1'b1;
      repeat (H + 4 - 6) @(negedge clk);
      chk("glitch_busy_low", 64'(rx_busy), 64'd0);
      idle_bits(3);
      chk("glitch_no_valid", 64'(n_valid), 64'(v0));
      chk("glitch_no_ferr", 64'(n_ferr), 64'(f0));

      // Framing error on byte 3 discards the partial word.
      send_byte(8'hDE, 1'b1);
      send_byte(8'hAD, 1'b1);
      send_byte(8'hBE, 1'b0);
      idle_bits(2);
      chk("ferr_count", 64'(n_ferr), 64'(f0 + 1));
      chk("ferr_busy_clear", 64'(rx_busy), 64'd0);
      send_word(64'h1122_3344_5566_7788);
      idle_bits(2);
      drain("drain_ferr");

      // Timeout discards three orphan bytes.
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      idle_bits(2);
      chk("to_busy_partial", 64'(rx_busy), 64'd1);
      idle_bits(TO);
      chk("to_busy_cleared", 64'(rx_busy), 64'd0);
      send_word(64'hA5A5_A5A5_5A5A_5A5A);
      idle_bits(2);
      drain("drain_to");

      // Reset in the middle of byte 5.
      v0 = n_valid;
      for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b1);
      uart_rxd = 1'b0;
      repeat (3 * G) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_data_64", data_64, 64'd0);
      chk("mid_rst_valid", 64'(data_valid), 64'd0);
      chk("mid_rst_ferr", 64'(frame_err), 64'd0);
      chk("mid_rst_busy", 64'(rx_busy), 64'd0);
      uart_rxd = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_bits(3);
      chk("post_rst_no_valid", 64'(n_valid), 64'(v0));
      send_word(64'h0F1E_2D3C_4B5A_6978);
      idle_bits(2);
      drain("drain_rst");

      chk("total_valid", 64'(n_valid), 64'd6);
      chk("total_ferr", 64'(n_ferr), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
